wishbone_master_agent: RTL and testbench
========================================

Name: wishbone_master_agent

Overview:
Single-transaction Wishbone B4 classic master. It sits directly downstream of the DMA controller state machine and converts a one-cycle start command (read or write, address, write data) into one bus cycle. It returns a one-cycle done pulse with the read data, plus an error flag. Bus-cycle supervision is handled internally: a timeout watchdog and bounded RTY retries.

Parameters:
DATA_WIDTH, 32, width of data bus and of i_wdata/o_rdata
ADDR_WIDTH, 32, byte-address width
SEL_WIDTH, DATA_WIDTH/8, byte-select width
TIMEOUT_CYCLES, 256, max cycles waiting for ACK/ERR/RTY per attempt; 0 disables watchdog
MAX_RETRY, 3, max re-issues after RTY before reporting error

Ports:
i_clk  in  1  clock, all logic on rising edge
i_rst  in  1  synchronous, active-high reset
i_start  in  1  command strobe, sampled only in IDLE
i_we  in  1  1 = write, 0 = read; sampled with i_start
i_addr  in  ADDR_WIDTH  byte address; sampled with i_start
i_wdata  in  DATA_WIDTH  write data; sampled with i_start
o_done  out  1  one-cycle completion pulse (success or error)
o_rdata  out  DATA_WIDTH  read data; valid while o_done=1, held until next o_done
o_err  out  1  valid with o_done; 1 = ERR, timeout, or retries exhausted
o_busy  out  1  1 from the cycle after accepted i_start through the o_done cycle
o_wb_cyc  out  1  Wishbone CYC_O
o_wb_stb  out  1  Wishbone STB_O
o_wb_we  out  1  Wishbone WE_O
o_wb_adr  out  ADDR_WIDTH  Wishbone ADR_O
o_wb_dat  out  DATA_WIDTH  Wishbone DAT_O
o_wb_sel  out  SEL_WIDTH  Wishbone SEL_O
i_wb_dat  in  DATA_WIDTH  Wishbone DAT_I
i_wb_ack  in  1  Wishbone ACK_I
i_wb_err  in  1  Wishbone ERR_I
i_wb_rty  in  1  Wishbone RTY_I

Behaviour:
- Reset (i_rst=1 at a rising edge): state IDLE. All outputs 0, including o_rdata. Timeout and retry counters cleared. Reset mid-transaction drops CYC/STB at that edge and produces no o_done.
- All outputs are registered; there is no combinational path from inputs to outputs.
- States: IDLE, BUS, GAP, RESP.
- IDLE: on i_start=1, latch we/addr/wdata, go to BUS, and assert CYC, STB, WE, ADR, DAT (writes), and SEL=all ones at the same edge. Latency: i_start at cycle N gives CYC/STB high in cycle N+1.
- BUS: hold CYC/STB and all bus outputs stable. The watchdog increments every cycle. Termination priority, evaluated each cycle: ERR > ACK > RTY > timeout.
  - ERR: go to RESP with err=1.
  - ACK: go to RESP with err=0; on reads, capture i_wb_dat into o_rdata.
  - RTY: if retry count < MAX_RETRY, increment it and go to GAP; otherwise go to RESP with err=1.
  - Timeout: if TIMEOUT_CYCLES≠0 and the watchdog has counted TIMEOUT_CYCLES cycles with no termination, go to RESP with err=1.
  - Every exit from BUS drops CYC/STB at the same edge.
- GAP: CYC/STB low for exactly one cycle; watchdog cleared; then back to BUS with the same latched command.
- RESP: o_done=1 and o_err valid for exactly this one cycle. The next state is IDLE.
  - On error, o_rdata is driven to 0.
  - On a successful write, o_rdata keeps its previous value.
  - RESP→IDLE means back-to-back commands run with a minimum 3-cycle spacing between i_start pulses (start, BUS, RESP).
- i_start outside IDLE is ignored; no queuing.
- Latched command is immune to input changes after the accept cycle.
- A zero-wait slave (ACK in the first BUS cycle) gives i_start at N → o_done at N+2.
- When CYC is low, WE/ADR/DAT/SEL are 0.
- The watchdog is wide enough to count TIMEOUT_CYCLES without wrap.
- The retry counter is reset on every new command.

Test Plan:
- Read, zero-wait slave: i_start, i_we=0, i_addr=0x1000; slave ACKs first cycle with DAT_I=0xDEADBEEF → CYC high 1 cycle; o_done at N+2 with o_rdata=0xDEADBEEF, o_err=0.
- Write, 3 wait states: i_we=1, i_addr=0x2004, i_wdata=0xA5A5_0001 → CYC/STB/WE high 4 cycles, ADR/DAT stable, SEL=0xF; o_done with o_err=0.
- ERR plus ACK asserted in the same cycle on a read → o_done with o_err=1, o_rdata=0.
- RTY on 3 consecutive attempts, ACK on the 4th (MAX_RETRY=3) → three 1-cycle CYC-low gaps; success with o_err=0. RTY on all 4 attempts → o_err=1.
- Silent slave, TIMEOUT_CYCLES=8 → CYC high exactly 8 cycles, then o_done with o_err=1; i_start pulses while busy are ignored.
- i_rst asserted during the 2nd wait cycle → CYC/STB low next edge; no o_done; a new command completes normally afterwards.

Source files
------------

// File: rtl/wishbone_master_agent.sv
// Single-transaction Wishbone B4 classic master: one start command becomes one bus cycle,
// supervised by a per-attempt timeout watchdog and a bounded RTY retry counter.
module wishbone_master_agent #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int SEL_WIDTH      = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int MAX_RETRY      = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_err,
    output logic                  o_busy,
    output logic                  o_wb_cyc,
    output logic                  o_wb_stb,
    output logic                  o_wb_we,
    output logic [ADDR_WIDTH-1:0] o_wb_adr,
    output logic [DATA_WIDTH-1:0] o_wb_dat,
    output logic [SEL_WIDTH-1:0]  o_wb_sel,
    input  logic [DATA_WIDTH-1:0] i_wb_dat,
    input  logic                  i_wb_ack,
    input  logic                  i_wb_err,
    input  logic                  i_wb_rty
);

    typedef enum logic [1:0] {IDLE, BUS, GAP, RESP} state_t;

    // The watchdog only has to reach TIMEOUT_CYCLES-1 before it fires.
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int RT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    state_t                state_q, state_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [WD_W-1:0]       wdog_q, wdog_d;
    logic [RT_W-1:0]       retry_q, retry_d;
    logic                  done_d, err_d, cyc_d;
    logic [DATA_WIDTH-1:0] rdata_d;

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wdog_d  = wdog_q;
        retry_d = retry_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        rdata_d = o_rdata;

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    we_d    = i_we;
                    addr_d  = i_addr;
                    wdata_d = i_wdata;
                    wdog_d  = '0;
                    retry_d = '0;
                    state_d = BUS;
                end
            end
            BUS: begin
                if (i_wb_err) begin
                    state_d = RESP;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else if (i_wb_ack) begin
                    state_d = RESP;
                    done_d  = 1'b1;
                    if (!we_q) rdata_d = i_wb_dat;
                end else if (i_wb_rty) begin
                    if (32'(retry_q) < MAX_RETRY) begin
                        retry_d = retry_q + 1'b1;
                        state_d = GAP;
                    end else begin
                        state_d = RESP;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end
                end else if (TIMEOUT_CYCLES != 0 && 32'(wdog_q) == TIMEOUT_CYCLES - 1) begin
                    state_d = RESP;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            GAP: begin
                wdog_d  = '0;
                state_d = BUS;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        cyc_d = (state_d == BUS);
    end

    // Bus outputs are registered from the next state so CYC rises on the accept edge.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wdog_q   <= '0;
            retry_q  <= '0;
            o_done   <= 1'b0;
            o_err    <= 1'b0;
            o_rdata  <= '0;
            o_busy   <= 1'b0;
            o_wb_cyc <= 1'b0;
            o_wb_stb <= 1'b0;
            o_wb_we  <= 1'b0;
            o_wb_adr <= '0;
            o_wb_dat <= '0;
            o_wb_sel <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wdog_q   <= wdog_d;
            retry_q  <= retry_d;
            o_done   <= done_d;
            o_err    <= err_d;
            o_rdata  <= rdata_d;
            o_busy   <= (state_d != IDLE);
            o_wb_cyc <= cyc_d;
            o_wb_stb <= cyc_d;
            o_wb_we  <= cyc_d & we_d;
            o_wb_adr <= cyc_d ? addr_d : '0;
            o_wb_dat <= (cyc_d && we_d) ? wdata_d : '0;
            o_wb_sel <= cyc_d ? {SEL_WIDTH{1'b1}} : '0;
        end
    end

endmodule

// File: tb/tb_wishbone_master_agent.sv
// Directed bench for wishbone_master_agent: a configurable slave model answers each
// command, and a scoreboard queue holds the expected completion of every command issued.
module tb_wishbone_master_agent;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          i_rst, i_start, i_we;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_wdata;
    logic          o_done, o_err, o_busy;
    logic [DW-1:0] o_rdata;
    logic          o_wb_cyc, o_wb_stb, o_wb_we;
    logic [AW-1:0] o_wb_adr;
    logic [DW-1:0] o_wb_dat;
    logic [SW-1:0] o_wb_sel;
    logic [DW-1:0] i_wb_dat;
    logic          i_wb_ack, i_wb_err, i_wb_rty;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wishbone_master_agent #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SEL_WIDTH(SW),
        .TIMEOUT_CYCLES(8), .MAX_RETRY(3)
    ) dut (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_we(i_we),
        .i_addr(i_addr), .i_wdata(i_wdata),
        .o_done(o_done), .o_rdata(o_rdata), .o_err(o_err), .o_busy(o_busy),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
        .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel),
        .i_wb_dat(i_wb_dat), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err), .i_wb_rty(i_wb_rty)
    );

    // Slave model: answers after slv_wait cycles of CYC, with RTY for the first slv_rty attempts.
    typedef enum int {S_ACK, S_ERRACK, S_SILENT} slv_mode_t;
    slv_mode_t     slv_mode = S_ACK;
    int            slv_wait = 0;
    int            slv_rty  = 0;
    logic [DW-1:0] slv_data = '0;
    int            cnt = 0;
    int            att = 0;
    logic          live;

    assign live     = o_wb_cyc && o_wb_stb && (cnt == slv_wait) && (slv_mode != S_SILENT);
    assign i_wb_rty = live && (att < slv_rty);
    assign i_wb_ack = live && (att >= slv_rty);
    assign i_wb_err = live && (att >= slv_rty) && (slv_mode == S_ERRACK);
    assign i_wb_dat = live ? slv_data : 32'h0BAD_0BAD;

    always_ff @(posedge clk) begin
        cnt <= o_wb_cyc ? cnt + 1 : 0;
        if (!o_busy)       att <= 0;
        else if (i_wb_rty) att <= att + 1;
    end

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one command, follow the bus until o_done, then score the completion.
    task automatic run_cmd(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input logic [DW-1:0] exp_rdata, input logic exp_err,
                           input int exp_high, input int exp_gaps, input bit poke);
        exp_t e;
        int   high = 0;
        int   gaps = 0;
        int   lat  = 0;
        bit   done_seen = 0;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        i_we = we; i_addr = addr; i_wdata = wdata; i_start = 1'b1;
        sb.push_back(e);
        step();
        i_start = 1'b0; i_we = ~we; i_addr = ~addr; i_wdata = ~wdata;
        for (int k = 1; k <= 64; k++) begin
            if (k == 1) chk("busy_after_accept", 80'(o_busy), 80'(1));
            if (o_done) begin
                done_seen = 1;
                lat = k;
                break;
            end
            if (o_wb_cyc) begin
                high++;
                chk("bus_stable", {o_wb_stb, o_wb_we, o_wb_adr, o_wb_dat, o_wb_sel},
                    {1'b1, we, addr, (we ? wdata : 32'h0), 4'hF});
            end else begin
                if (high > 0) gaps++;
                chk("bus_idle_zero", {o_wb_stb, o_wb_we, o_wb_adr, o_wb_dat, o_wb_sel}, 80'(0));
            end
            i_start = (poke && k == 3);
            step();
        end
        i_start = 1'b0;
        chk("done_seen", 80'(done_seen), 80'(1));
        e = sb.pop_front();
        if (done_seen) begin
            chk("rdata", 80'(o_rdata), 80'(e.rdata));
            chk("err", 80'(o_err), 80'(e.err));
            chk("busy_at_done", 80'(o_busy), 80'(1));
            chk("cyc_high_cycles", 80'(high), 80'(exp_high));
            chk("gap_cycles", 80'(gaps), 80'(exp_gaps));
            chk("latency", 80'(lat), 80'(exp_high + exp_gaps + 1));
            step();
            chk("done_one_cycle", {o_done, o_busy, o_wb_cyc}, 80'(0));
            chk("rdata_held", 80'(o_rdata), 80'(e.rdata));
            if (poke) begin
                for (int j = 0; j < 3; j++) step();
                chk("poke_ignored", {o_wb_cyc, o_busy, o_done}, 80'(0));
            end
        end
    endtask

    initial begin
        bit stray_done;
        i_rst = 1'b1; i_start = 1'b0; i_we = 1'b0; i_addr = '0; i_wdata = '0;
        step(); step();
        chk("reset_outputs", {o_done, o_err, o_busy, o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel},
            80'(0));
        chk("reset_buses", {o_wb_adr, o_wb_dat}, 80'(0));
        chk("reset_rdata", 80'(o_rdata), 80'(0));
        i_rst = 1'b0;
        step();

        slv_mode = S_ACK; slv_wait = 0; slv_rty = 0; slv_data = 32'hDEAD_BEEF;
        run_cmd(1'b0, 32'h1000, 32'h0, 32'hDEAD_BEEF, 1'b0, 1, 0, 0);

        slv_wait = 3; slv_data = 32'h5555_AAAA;
        run_cmd(1'b1, 32'h2004, 32'hA5A5_0001, 32'hDEAD_BEEF, 1'b0, 4, 0, 0);

        slv_mode = S_ERRACK; slv_wait = 0; slv_data = 32'h1111_2222;
        run_cmd(1'b0, 32'h3000, 32'h0, 32'h0, 1'b1, 1, 0, 0);

        slv_mode = S_ACK; slv_rty = 3; slv_data = 32'h1234_5678;
        run_cmd(1'b0, 32'h4000, 32'h0, 32'h1234_5678, 1'b0, 4, 3, 0);

        // Reset during the second wait cycle of a read.
        slv_rty = 0; slv_wait = 5; slv_data = 32'h9999_0000;
        i_we = 1'b0; i_addr = 32'h4800; i_start = 1'b1;
        step();
        i_start = 1'b0;
        chk("rst_mid_cyc_up", 80'(o_wb_cyc), 80'(1));
        step();
        i_rst = 1'b1;
        step();
        chk("rst_mid_dropped", {o_wb_cyc, o_wb_stb, o_done, o_busy, o_err}, 80'(0));
        chk("rst_mid_rdata", 80'(o_rdata), 80'(0));
        i_rst = 1'b0;
        stray_done = 0;
        for (int j = 0; j < 8; j++) begin
            if (o_done || o_wb_cyc) stray_done = 1;
            step();
        end
        chk("rst_mid_no_done", 80'(stray_done), 80'(0));

        slv_wait = 1; slv_data = 32'hCAFE_F00D;
        run_cmd(1'b0, 32'h5000, 32'h0, 32'hCAFE_F00D, 1'b0, 2, 0, 0);

        slv_wait = 0; slv_rty = 4;
        run_cmd(1'b1, 32'h6000, 32'h0000_0077, 32'h0, 1'b1, 4, 3, 0);

        slv_mode = S_SILENT; slv_rty = 0;
        run_cmd(1'b0, 32'h7000, 32'h0, 32'h0, 1'b1, 8, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
